simon_input_conditioner: RTL and testbench

Front end between the four raw player push-buttons and the Simon game core. It synchronizes and debounces each button and allows one accepted press per physical press-release cycle. Each accepted press becomes a 2-bit button index plus a single-cycle press pulse, which feed the core's playerNum/playerPressed inputs. The block locks out input while Simon is playing its sequence and rejects simultaneous multi-button presses.

---
 rtl/simon_pkg.sv | 30 +++
 rtl/simon_btn_debounce.sv | 55 +++++
 rtl/simon_input_conditioner.sv | 124 ++++++++++++
 tb/tb_simon_input_conditioner.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simon_pkg
//  Purpose  : Shared types and constants for the Simon player-input front end.
//  Revision : 1.0 - initial release
// ============================================================================
package simon_pkg;

   localparam int NUM_BTN = 4;

   typedef logic [1:0] btn_idx_t;

   typedef enum logic [1:0] {
      WAIT_REL = 2'd0,
      IDLE     = 2'd1,
      PRESSED  = 2'd2
   } cond_state_t;

   // Index of the lowest set bit; only meaningful when at least one bit is set.
   function automatic btn_idx_t first_set_idx(input logic [NUM_BTN-1:0] v);
      btn_idx_t idx;
      idx = '0;
      for (int i = NUM_BTN - 1; i >= 0; i--) begin
         if (v[i]) idx = btn_idx_t'(i);
      end
      return idx;
   endfunction

endpackage
`default_nettype wire

// File: rtl/simon_btn_debounce.sv
`default_nettype none
// ============================================================================
//  Module   : simon_btn_debounce
//  Purpose  : Synchronizes one raw push-button and debounces it into a stable
//             level that only changes after DEBOUNCE_TICKS stable cycles.
//  Revision : 1.0 - initial release
// ============================================================================
module simon_btn_debounce #(
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_TICKS = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic level
);

   // Counter is 4 bits wide, enough for the legal DEBOUNCE_TICKS range 1..15.
   localparam logic [3:0] c_CNT_MAX = 4'(DEBOUNCE_TICKS - 1);

   logic [SYNC_STAGES-1:0] r_sync;
   logic [3:0]             r_cnt;
   logic                   r_level;
   logic                   w_synced;

   assign w_synced = r_sync[SYNC_STAGES-1];
   assign level    = r_level;

   // Metastability chain: shift the asynchronous level through SYNC_STAGES flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], raw};
      end
   end

   // Count consecutive cycles where the synced value disagrees with the level;
   // flip the level on the DEBOUNCE_TICKS-th disagreeing cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cnt   <= '0;
         r_level <= 1'b0;
      end else if (w_synced == r_level) begin
         r_cnt <= '0;
      end else if (r_cnt == c_CNT_MAX) begin
         r_level <= ~r_level;
         r_cnt   <= '0;
      end else begin
         r_cnt <= r_cnt + 4'd1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/simon_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : simon_input_conditioner
//  Purpose  : Turns four raw Simon buttons into single accepted presses
//             (index + one-cycle pulse), with lockout during Simon's turn and
//             rejection of simultaneous multi-button presses.
//  Options  : define SIMON_PRESS_COUNT_EN to add the saturating press_count port.
//  Revision : 1.0 - initial release
// ============================================================================
module simon_input_conditioner
   import simon_pkg::*;
#(
   parameter int SYNC_STAGES    = 2,
   parameter int DEBOUNCE_TICKS = 3
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               simon_turn,
   output logic [1:0]         player_num,
   output logic               player_pressed,
   output logic [NUM_BTN-1:0] btn_held,
   output logic               conflict
`ifdef SIMON_PRESS_COUNT_EN
   ,
   output logic [7:0]         press_count
`endif
);

   logic [NUM_BTN-1:0] w_level;
   logic [NUM_BTN-1:0] r_level_d;
   logic [NUM_BTN-1:0] w_rise;
   logic [2:0]         w_rise_cnt;
   cond_state_t        r_state;
   cond_state_t        w_next_state;
   logic               w_accept;
   logic               w_conflict;
   btn_idx_t           r_player_num;
   logic               r_pressed;
   logic               r_conflict;

   for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
      simon_btn_debounce #(
         .SYNC_STAGES    (SYNC_STAGES),
         .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
      ) u_debounce (
         .clk   (clk),
         .reset (reset),
         .raw   (btn_raw[g]),
         .level (w_level[g])
      );
   end

   assign w_rise     = w_level & ~r_level_d;
   assign w_rise_cnt = 3'($countones(w_rise));

   // Acceptance FSM: WAIT_REL guarantees a full release (outside Simon's turn)
   // before any new press can be accepted.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_conflict   = 1'b0;
      case (r_state)
         WAIT_REL: begin
            if (w_level == '0 && !simon_turn) w_next_state = IDLE;
         end
         IDLE: begin
            if (simon_turn) begin
               w_next_state = WAIT_REL;
            end else if (w_rise_cnt == 3'd1) begin
               w_accept     = 1'b1;
               w_next_state = PRESSED;
            end else if (w_rise_cnt > 3'd1) begin
               w_conflict   = 1'b1;
               w_next_state = WAIT_REL;
            end
         end
         PRESSED: begin
            if (simon_turn)          w_next_state = WAIT_REL;
            else if (w_level == '0)  w_next_state = IDLE;
         end
         default: w_next_state = WAIT_REL;
      endcase
   end

   // State, edge-detect history and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= WAIT_REL;
         r_level_d    <= '0;
         r_player_num <= '0;
         r_pressed    <= 1'b0;
         r_conflict   <= 1'b0;
      end else begin
         r_state    <= w_next_state;
         r_level_d  <= w_level;
         r_pressed  <= w_accept;
         r_conflict <= w_conflict;
         if (w_accept) r_player_num <= first_set_idx(w_rise);
      end
   end

   assign player_num     = r_player_num;
   assign player_pressed = r_pressed;
   assign conflict       = r_conflict;
   assign btn_held       = w_level;

`ifdef SIMON_PRESS_COUNT_EN
   logic [7:0] r_press_count;

   // Saturating count of accepted presses, updated together with the pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_press_count <= '0;
      end else if (w_accept && r_press_count != 8'hFF) begin
         r_press_count <= r_press_count + 8'd1;
      end
   end

   assign press_count = r_press_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_simon_input_conditioner.sv
`default_nettype none
// ============================================================================
//  Module   : tb_simon_input_conditioner
//  Purpose  : Scoreboard bench for simon_input_conditioner with a behavioural
//             reference model; directed scenarios followed by random presses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_simon_input_conditioner;
   import simon_pkg::*;

   localparam int SYNC_STAGES    = 2;
   localparam int DEBOUNCE_TICKS = 3;
   localparam int EV_PRESS       = 0;
   localparam int EV_CONFLICT    = 1;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [3:0] btn_raw = 4'b0;
   logic       simon_turn = 1'b0;
   logic [1:0] player_num;
   logic       player_pressed;
   logic [3:0] btn_held;
   logic       conflict;
`ifdef SIMON_PRESS_COUNT_EN
   logic [7:0] press_count;
`endif

   simon_input_conditioner #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .btn_raw        (btn_raw),
      .simon_turn     (simon_turn),
      .player_num     (player_num),
      .player_pressed (player_pressed),
      .btn_held       (btn_held),
      .conflict       (conflict)
`ifdef SIMON_PRESS_COUNT_EN
      ,
      .press_count    (press_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      int kind;
      int num;
      int edge_no;
   } ev_t;

   ev_t exp_q[$];
   int  checks = 0;
   int  errors = 0;
   int  edge_count = 0;

   always @(posedge clk) edge_count <= edge_count + 1;

   // ---------------- reference model state ----------------
   logic [3:0] m_hist[$];      // raw samples, newest first
   logic [3:0] m_level;
   logic [3:0] m_level_prev;
   int         m_run[4];
   int         m_mode;         // 0 = needs release, 1 = ready, 2 = holding an accepted press
   int         m_last;
   logic [3:0] exp_held;
   bit         m_pushed_press;
   int         step_edge;

   // ---------------- monitor-side state ----------------
   ev_t        mon_e;
   int         mon_num = 0;
   int         mon_count = 0;
   int         press_seen = 0;
   int         last_press_edge = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %0d required %0d (edge %0d)", name, act, req, edge_count);
      end
   endtask

   task automatic model_clear();
      m_hist.delete();
      m_level      = '0;
      m_level_prev = '0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
      m_mode    = 0;
      m_last    = 0;
      exp_held  = '0;
      exp_q.delete();
      mon_num   = 0;
      mon_count = 0;
   endtask

   // Predict the effect of the upcoming clock edge given the inputs now applied.
   task automatic model_edge(input logic [3:0] raw, input logic turn);
      logic [3:0] synced;
      logic [3:0] rise;
      logic [3:0] held;
      int         nrise;
      int         idx;
      ev_t        e;
      // The debouncer sees the raw value from SYNC_STAGES edges ago.
      synced = (m_hist.size() >= SYNC_STAGES) ? m_hist[SYNC_STAGES-1] : 4'b0;
      m_hist.push_front(raw);
      if (m_hist.size() > SYNC_STAGES) void'(m_hist.pop_back());
      held         = m_level;
      rise         = m_level & ~m_level_prev;
      m_level_prev = m_level;
      for (int i = 0; i < 4; i++) begin
         if (synced[i] != m_level[i]) begin
            m_run[i]++;
            if (m_run[i] == DEBOUNCE_TICKS) begin
               m_level[i] = synced[i];
               m_run[i]   = 0;
            end
         end else begin
            m_run[i] = 0;
         end
      end
      nrise = $countones(rise);
      idx   = 0;
      for (int i = 0; i < 4; i++) if (rise[i]) idx = i;
      m_pushed_press = 1'b0;
      e.edge_no = edge_count + 1;
      e.kind    = EV_PRESS;
      e.num     = 0;
      case (m_mode)
         0: if (held == 4'b0 && !turn) m_mode = 1;
         1: begin
            if (turn) m_mode = 0;
            else if (nrise == 1) begin
               e.kind = EV_PRESS; e.num = idx; exp_q.push_back(e);
               m_last = idx; m_mode = 2; m_pushed_press = 1'b1;
            end else if (nrise > 1) begin
               e.kind = EV_CONFLICT; e.num = m_last; exp_q.push_back(e);
               m_mode = 0;
            end
         end
         default: begin
            if (turn) m_mode = 0;
            else if (held == 4'b0) m_mode = 1;
         end
      endcase
      exp_held = m_level;
   endtask

   task automatic step(input logic [3:0] raw, input logic turn);
      @(negedge clk);
      #1;
      btn_raw    = raw;
      simon_turn = turn;
      step_edge  = edge_count + 1;
      model_edge(raw, turn);
   endtask

   task automatic steps(input int n, input logic [3:0] raw, input logic turn);
      for (int i = 0; i < n; i++) step(raw, turn);
   endtask

   // Assert reset now, verify outputs clear immediately, release before next edge.
   task automatic reset_now();
      reset = 1'b1;
      #1;
      chk("rst_player_pressed", player_pressed, 0);
      chk("rst_conflict", conflict, 0);
      chk("rst_player_num", player_num, 0);
      chk("rst_btn_held", btn_held, 0);
`ifdef SIMON_PRESS_COUNT_EN
      chk("rst_press_count", press_count, 0);
`endif
      model_clear();
      @(negedge clk);
      #1;
      reset = 1'b0;
      model_edge(btn_raw, simon_turn);
   endtask

   // Monitor: compare every observed pulse against the scoreboard queue.
   always @(negedge clk) begin
      if (!reset) begin
         chk("btn_held", btn_held, exp_held);
         if (player_pressed || conflict) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_pulse", {player_pressed, conflict}, 2'b00);
            end else begin
               mon_e = exp_q.pop_front();
               chk("pulse_edge", edge_count, mon_e.edge_no);
               chk("pulse_kind", {player_pressed, conflict},
                   (mon_e.kind == EV_PRESS) ? 2'b10 : 2'b01);
               chk("pulse_player_num", player_num, mon_e.num);
               if (mon_e.kind == EV_PRESS) begin
                  mon_num = mon_e.num;
                  press_seen++;
                  last_press_edge = edge_count;
                  if (mon_count < 255) mon_count++;
`ifdef SIMON_PRESS_COUNT_EN
                  chk("press_count", press_count, mon_count);
`endif
               end
            end
         end else begin
            chk("player_num_hold", player_num, mon_num);
            if (exp_q.size() > 0 && exp_q[0].edge_no <= edge_count) begin
               mon_e = exp_q.pop_front();
               chk("missing_pulse", {player_pressed, conflict},
                   (mon_e.kind == EV_PRESS) ? 2'b10 : 2'b01);
            end
         end
      end
   end

   initial begin
      int t1_start;
      int seen_before;
      int seg_len;
      logic [3:0] seg_raw;
      logic seg_turn;
      bit got;

      model_clear();
      #2;
      reset_now();

      // Single press of button 2: latency, index, single pulse, re-press.
      seen_before = press_seen;
      step(4'b0100, 1'b0);
      t1_start = step_edge;
      steps(9, 4'b0100, 1'b0);
      chk("t1_latency", last_press_edge - t1_start + 1, SYNC_STAGES + DEBOUNCE_TICKS + 1);
      chk("t1_single_pulse", press_seen - seen_before, 1);
      chk("t1_num", player_num, 2);
      steps(8, 4'b0000, 1'b0);
      steps(10, 4'b0100, 1'b0);
      chk("t1_repress", press_seen - seen_before, 2);
      steps(8, 4'b0000, 1'b0);

      // Two-cycle glitch on button 1 must be filtered.
      seen_before = press_seen;
      steps(2, 4'b0010, 1'b0);
      steps(10, 4'b0000, 1'b0);
      chk("t2_glitch_no_press", press_seen - seen_before, 0);

      // Simultaneous buttons 0 and 1: conflict, then a clean press of 3.
      steps(8, 4'b0011, 1'b0);
      steps(8, 4'b0000, 1'b0);
      steps(8, 4'b1000, 1'b0);
      chk("t3_num", player_num, 3);
      steps(8, 4'b0000, 1'b0);

      // Press held across Simon's turn must not fire until released.
      seen_before = press_seen;
      steps(8, 4'b0001, 1'b1);
      steps(8, 4'b0001, 1'b0);
      chk("t4_locked", press_seen - seen_before, 0);
      steps(8, 4'b0000, 1'b0);
      steps(8, 4'b0001, 1'b0);
      chk("t4_after_release", press_seen - seen_before, 1);
      steps(8, 4'b0000, 1'b0);

      // Second button while first held: ignored; then IDLE accepts again.
      seen_before = press_seen;
      steps(8, 4'b0010, 1'b0);
      steps(8, 4'b0110, 1'b0);
      steps(8, 4'b0000, 1'b0);
      chk("t5_ignored_second", press_seen - seen_before, 1);
      steps(8, 4'b0100, 1'b0);
      steps(8, 4'b0000, 1'b0);

`ifdef SIMON_PRESS_COUNT_EN
      // Saturation of the press counter.
      for (int n = 0; n < 260; n++) begin
         steps(7, 4'b0001 << (n % 4), 1'b0);
         steps(6, 4'b0000, 1'b0);
      end
      chk("press_count_sat", press_count, 255);
`endif

      // Reset while a pulse is on the output.
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         step(4'b0001, 1'b0);
         got = m_pushed_press;
      end
      chk("t6_press_reached", got, 1);
      if (got) begin
         @(posedge clk);
         #1;
         chk("t6_pulse_before_reset", player_pressed, 1);
         reset_now();
      end
      steps(10, 4'b0001, 1'b0);
      steps(8, 4'b0000, 1'b0);

      // Random traffic against the model.
      seg_turn = 1'b0;
      for (int s = 0; s < 300; s++) begin
         case ($urandom_range(0, 19))
            0, 1, 2, 3, 4, 5, 6, 7, 8, 9: seg_raw = 4'b0000;
            10, 11, 12, 13, 14, 15, 16:   seg_raw = 4'b0001 << $urandom_range(0, 3);
            default:                      seg_raw = 4'($urandom_range(0, 15));
         endcase
         if ($urandom_range(0, 9) == 0) seg_turn = ~seg_turn;
         seg_len = $urandom_range(1, 8);
         steps(seg_len, seg_raw, seg_turn);
      end

      steps(15, 4'b0000, 1'b0);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
